// File: rtl/axil_master_bridge_pkg.sv
// Shared types and widths for the AXI4-Lite master bridge.
package axil_master_bridge_pkg;

  localparam int AXIL_ADDR_W     = 32;
  localparam int AXIL_DATA_W     = 32;
  localparam int AXIL_STRB_W     = 4;
  localparam int TIMEOUT_CYC_DEF = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RA   = 3'd2,
    RD   = 3'd3,
    RSP  = 3'd4
  } state_t;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding cmd/rsp port to AXI4-Lite master (AW/W/AR/R, no B) with a bus-wait timeout.
// Best case: write rsp 2 cycles after cmd, read rsp 3 cycles; rsp held until rsp_ready.
module axil_master_bridge
  import axil_master_bridge_pkg::*;
#(
  parameter int                     TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [AXIL_DATA_W-1:0] ERR_RDATA   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [AXIL_ADDR_W-1:0] cmd_addr,
  input  logic [AXIL_DATA_W-1:0] cmd_wdata,
  input  logic [AXIL_STRB_W-1:0] cmd_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [AXIL_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [AXIL_ADDR_W-1:0] m_axi_awaddr,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [AXIL_DATA_W-1:0] m_axi_wdata,
  output logic [AXIL_STRB_W-1:0] m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  output logic [AXIL_ADDR_W-1:0] m_axi_araddr,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [AXIL_DATA_W-1:0] m_axi_rdata,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state_q, state_d;

  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic [AXIL_ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [AXIL_ADDR_W-1:0] araddr_q, araddr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [AXIL_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [CNT_W-1:0]       to_cnt_q;

  logic aw_hs, w_hs, ar_hs, aw_fin, w_fin, timeout;

  assign aw_hs   = awvalid_q & m_axi_awready;
  assign w_hs    = wvalid_q & m_axi_wready;
  assign ar_hs   = arvalid_q & m_axi_arready;
  assign aw_fin  = aw_done_q | aw_hs;
  assign w_fin   = w_done_q | w_hs;
  assign timeout = (TIMEOUT_CYC != 0) && (to_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Completion is tested before timeout so a last-cycle handshake still succeeds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_we ? WR : RA;
      WR:      if ((aw_fin && w_fin) || timeout) state_d = RSP;
      RA:      if (ar_hs) state_d = RD;
               else if (timeout) state_d = RSP;
      RD:      if (m_axi_rvalid || timeout) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd_valid) begin
          if (cmd_we) begin
            awaddr_d = cmd_addr;
            wdata_d  = cmd_wdata;
            wstrb_d  = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_fin && w_fin) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else if (timeout) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RA: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
        end else if (timeout) begin
          arvalid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_RDATA;
        end
      end
      RD: begin
        if (m_axi_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = m_axi_rdata;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_RDATA;
        end
      end
      RSP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  // Cleared while idle so every transaction starts its bus wait from zero; saturates, never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q == IDLE) begin
      to_cnt_q <= '0;
    end else if ((state_q == WR || state_q == RA || state_q == RD) && to_cnt_q != CNT_MAX) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign m_axi_rready  = (state_q == IDLE) || (state_q == RD);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Scoreboard bench for axil_master_bridge: directed commands against a configurable AXI4-Lite slave.
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  axil_master_bridge #(.TIMEOUT_CYC(8), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  // slave configuration
  bit          sysio = 1'b1, ar_stuck = 1'b0, stale_inj = 1'b0, slv_clr = 1'b0;
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  logic [31:0] r_dat = '0, stale_dat = '0;
  logic        stale_rready = 1'b0;
  int          stale_cnt = 0;

  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_strb = '0;
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  int          hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: inputs are updated on the falling edge; handshakes are those the next rising edge samples.
  initial begin
    int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cd = 0;
    bit  r_pend = 1'b0, ar_hs_q = 1'b0, r_hs_q = 1'b0;
    forever begin
      @(negedge clk);
      if (slv_clr) begin
        r_pend = 1'b0; ar_hs_q = 1'b0; r_hs_q = 1'b0; rvalid = 1'b0; slv_clr = 1'b0;
      end
      if (ar_hs_q) begin r_pend = 1'b1; r_cd = r_lat; end
      if (r_hs_q) rvalid = 1'b0;
      if (sysio) begin
        awready = awvalid && wvalid;
        wready  = awvalid && wvalid;
      end else begin
        awready = awvalid && (aw_cnt >= aw_lat);
        wready  = wvalid && (w_cnt >= w_lat);
      end
      arready = arvalid && !ar_stuck && (ar_cnt >= ar_lat);
      aw_cnt = awvalid ? aw_cnt + 1 : 0;
      w_cnt  = wvalid ? w_cnt + 1 : 0;
      ar_cnt = arvalid ? ar_cnt + 1 : 0;
      if (stale_inj) begin
        rvalid = 1'b1; rdata = stale_dat; stale_inj = 1'b0;
        stale_rready = rready; stale_cnt++;
      end else if (r_pend && !rvalid) begin
        if (r_cd == 0) begin rvalid = 1'b1; rdata = r_dat; r_pend = 1'b0; end
        else r_cd--;
      end
      ar_hs_q = arvalid && arready;
      r_hs_q  = rvalid && rready;
    end
  end

  // AXI request-side checks: stable address/data while valid, per-transaction valid-cycle counts.
  initial forever begin
    @(negedge clk);
    if (awvalid) begin aw_cyc++; chk("awaddr_stable", awaddr, cur_addr); end
    if (wvalid) begin
      w_cyc++;
      chk("wdata_stable", wdata, cur_wdata);
      chk("wstrb_stable", {28'h0, wstrb}, {28'h0, cur_strb});
    end
    if (arvalid) begin ar_cyc++; chk("araddr_stable", araddr, cur_addr); end
  end

  // Response monitor: drives rsp_ready, checks stability, latency and data against the scoreboard.
  initial begin
    bit          prev_vld = 1'b0, prev_hs = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end else if (!prev_vld) begin
          if (sb[0].lat >= 0) chk("rsp_latency", cyc - sb[0].t0, sb[0].lat);
        end else if (!prev_hs) begin
          chk("rsp_rdata_stable", rsp_rdata, prev_rdata);
          chk("rsp_err_stable", {31'h0, rsp_err}, {31'h0, prev_err});
        end
        rsp_ready = (hold_cnt == 0);
        if (hold_cnt > 0) hold_cnt--;
        if (rsp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        end
        prev_hs = rsp_ready;
      end else begin
        rsp_ready = 1'b0;
        prev_hs = 1'b0;
      end
      prev_vld   = rsp_valid;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    cur_addr = addr; cur_wdata = wd; cur_strb = strb;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
    if (push) sb.push_back('{exp_rdata, exp_err, lat, cyc});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0 || !cmd_ready) chk({name, "_timeout"}, sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    chk({tag, "_rready"}, {31'h0, rready}, 32'h1);
    chk({tag, "_valids"}, {28'h0, awvalid, wvalid, arvalid, rsp_valid}, 32'h0);
    chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_awaddr"}, awaddr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_wstrb"}, {28'h0, wstrb}, 32'h0);
    chk({tag, "_araddr"}, araddr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Sysio-style write, zero wait.
    sysio = 1'b1;
    issue(1'b1, 32'h0000_0404, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0, 2, 1'b1);
    wait_done("wr_sysio");
    chk("wr_sysio_aw_cycles", aw_cyc, 1);
    chk("wr_sysio_w_cycles", w_cyc, 1);

    // Read, R beat one cycle after AR handshake.
    r_dat = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0F00, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 3, 1'b1);
    wait_done("rd_basic");
    chk("rd_basic_ar_cycles", ar_cyc, 1);

    // Write with W accepted 3 cycles before AW.
    sysio = 1'b0; aw_lat = 3; w_lat = 0;
    issue(1'b1, 32'h0000_1008, 32'h1357_9BDF, 4'h5, 32'h0, 1'b0, 5, 1'b1);
    wait_done("wr_split");
    chk("wr_split_aw_cycles", aw_cyc, 4);
    chk("wr_split_w_cycles", w_cyc, 1);

    // Read timeout: arready stuck low.
    ar_stuck = 1'b1;
    issue(1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h0, 1'b1, 9, 1'b1);
    wait_done("rd_timeout");
    chk("rd_timeout_ar_cycles", ar_cyc, 8);
    ar_stuck = 1'b0;

    // Stale R beat while idle is swallowed without a response.
    stale_dat = 32'hBAD0_0BAD;
    stale_inj = 1'b1;
    repeat (4) @(negedge clk);
    chk("stale_injected", stale_cnt, 1);
    chk("stale_rready", {31'h0, stale_rready}, 32'h1);
    chk("stale_no_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("stale_rvalid_consumed", {31'h0, rvalid}, 32'h0);
    r_dat = 32'h1234_5678;
    issue(1'b0, 32'h0000_0F04, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 1'b1);
    wait_done("rd_after_stale");

    // Write timeout: AW never accepted within the budget, W accepted at once.
    aw_lat = 20; w_lat = 0;
    issue(1'b1, 32'h0000_3000, 32'h0F0F_F0F0, 4'hC, 32'h0, 1'b1, 9, 1'b1);
    wait_done("wr_timeout");
    chk("wr_timeout_aw_cycles", aw_cyc, 8);
    chk("wr_timeout_w_cycles", w_cyc, 1);
    sysio = 1'b1; aw_lat = 0;

    // Response back-pressure for 5 cycles.
    hold_cnt = 5;
    r_dat = 32'h0BAD_F00D;
    issue(1'b0, 32'h0000_0F08, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 3, 1'b1);
    wait_done("rd_hold");
    chk("rd_hold_consumed", hold_cnt, 0);

    // Reset pulse while waiting in RD.
    r_lat = 4;
    r_dat = 32'hDEAD_0000;
    issue(1'b0, 32'h0000_0F10, 32'h0, 4'h0, 32'h0, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("rd_mid_rready", {31'h0, rready}, 32'h1);
    chk("rd_mid_arvalid", {31'h0, arvalid}, 32'h0);
    rst_n = 1'b0;
    slv_clr = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    r_lat = 0;
    r_dat = 32'h7777_0001;
    issue(1'b0, 32'h0000_0F0C, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 3, 1'b1);
    wait_done("rd_after_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
